// File: rtl/jogo_pkg.sv
// jogo_pkg: shared state codes and game constants for the memory game control unit
package jogo_pkg;
  localparam int N_RODADAS = 16;
  localparam int TIMEOUT_PADRAO = 5000;
  localparam logic [3:0] S_INICIAL = 4'h0;
  localparam logic [3:0] S_PREPARACAO = 4'h1;
  localparam logic [3:0] S_INICIA_RODADA = 4'h2;
  localparam logic [3:0] S_ESPERA_JOGADA = 4'h3;
  localparam logic [3:0] S_REGISTRA = 4'h4;
  localparam logic [3:0] S_COMPARACAO = 4'h5;
  localparam logic [3:0] S_PROXIMA_JOGADA = 4'h6;
  localparam logic [3:0] S_ESPERA_ESCRITA = 4'h7;
  localparam logic [3:0] S_REGISTRA_ESCRITA = 4'h8;
  localparam logic [3:0] S_ESCREVE_MEMORIA = 4'h9;
  localparam logic [3:0] S_PROXIMA_RODADA = 4'hA;
  localparam logic [3:0] S_FIM_ACERTOU = 4'hC;
  localparam logic [3:0] S_FIM_ERROU = 4'hD;
  localparam logic [3:0] S_FIM_TIMEOUT = 4'hE;
  typedef enum logic [3:0] {
    INICIAL = S_INICIAL,
    PREPARACAO = S_PREPARACAO,
    INICIA_RODADA = S_INICIA_RODADA,
    ESPERA_JOGADA = S_ESPERA_JOGADA,
    REGISTRA = S_REGISTRA,
    COMPARACAO = S_COMPARACAO,
    PROXIMA_JOGADA = S_PROXIMA_JOGADA,
    ESPERA_ESCRITA = S_ESPERA_ESCRITA,
    REGISTRA_ESCRITA = S_REGISTRA_ESCRITA,
    ESCREVE_MEMORIA = S_ESCREVE_MEMORIA,
    PROXIMA_RODADA = S_PROXIMA_RODADA,
    FIM_ACERTOU = S_FIM_ACERTOU,
    FIM_ERROU = S_FIM_ERROU,
    FIM_TIMEOUT = S_FIM_TIMEOUT
  } estado_t;
endpackage

// File: rtl/contador_timeout.sv
// contador_timeout: per-play wait timer, saturating at TIMEOUT_CICLOS-1
module contador_timeout #(
  parameter int LARGURA_T = 13,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam logic [LARGURA_T-1:0] MAX = LARGURA_T'(TIMEOUT_CICLOS - 1);
  logic [LARGURA_T-1:0] cnt_q, cnt_d;
  always_comb cnt_d = zera ? '0 : (conta && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign fim = cnt_q == MAX;
endmodule

// File: rtl/unidade_controle_exp6_desafio.sv
// unidade_controle_exp6_desafio: Moore control FSM for the memory game datapath
module unidade_controle_exp6_desafio
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int LARGURA_T = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       rodadaFinal,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       registraR,
  output logic       escreve,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);
  estado_t estado_q, estado_d;
  logic espera, fim_t;
  assign espera = estado_q == ESPERA_JOGADA || estado_q == ESPERA_ESCRITA;
  contador_timeout #(.LARGURA_T(LARGURA_T), .TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_timer (
    .clock(clock),
    .reset(reset),
    .zera(!espera),
    .conta(espera),
    .fim(fim_t)
  );
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:          estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:       estado_d = INICIA_RODADA;
      INICIA_RODADA:    estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:    estado_d = jogada ? REGISTRA : fim_t ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA:         estado_d = COMPARACAO;
      COMPARACAO:       estado_d = !igual ? FIM_ERROU :
                                   !enderecoIgualRodada ? PROXIMA_JOGADA :
                                   rodadaFinal ? FIM_ACERTOU : ESPERA_ESCRITA;
      PROXIMA_JOGADA:   estado_d = ESPERA_JOGADA;
      ESPERA_ESCRITA:   estado_d = jogada ? REGISTRA_ESCRITA : fim_t ? FIM_TIMEOUT : ESPERA_ESCRITA;
      REGISTRA_ESCRITA: estado_d = ESCREVE_MEMORIA;
      ESCREVE_MEMORIA:  estado_d = PROXIMA_RODADA;
      PROXIMA_RODADA:   estado_d = INICIA_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: estado_d = iniciar ? PREPARACAO : estado_q;
      default:          estado_d = INICIAL;
    endcase
  end
  always_ff @(posedge clock) estado_q <= reset ? INICIAL : estado_d;
  always_comb begin
    zeraE      = estado_q == PREPARACAO || estado_q == INICIA_RODADA;
    zeraR      = estado_q == PREPARACAO;
    contaE     = estado_q == PROXIMA_JOGADA || estado_q == REGISTRA_ESCRITA;
    contaR     = estado_q == PROXIMA_RODADA;
    registraR  = estado_q == REGISTRA || estado_q == REGISTRA_ESCRITA;
    escreve    = estado_q == ESCREVE_MEMORIA;
    ganhou     = estado_q == FIM_ACERTOU;
    db_timeout = estado_q == FIM_TIMEOUT;
    perdeu     = estado_q == FIM_ERROU || db_timeout;
    pronto     = ganhou || perdeu;
    db_estado  = estado_q;
  end
endmodule

// File: tb/tb_unidade_controle_exp6_desafio.sv
// tb_unidade_controle_exp6_desafio: directed checks of the game control FSM with a short timeout
module tb_unidade_controle_exp6_desafio;
  logic clock = 1'b0;
  logic reset = 1'b0, iniciar = 1'b0, jogada = 1'b0;
  logic igual = 1'b0, enderecoIgualRodada = 1'b0, rodadaFinal = 1'b0;
  logic zeraE, contaE, zeraR, contaR, registraR, escreve, pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;
  logic [9:0] outs;
  int total = 0, bad = 0;
  // expected output words: {zeraE,contaE,zeraR,contaR,registraR,escreve,pronto,ganhou,perdeu,db_timeout}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_PREP = 10'b1010000000;
  localparam logic [9:0] O_INIR = 10'b1000000000;
  localparam logic [9:0] O_REG  = 10'b0000100000;
  localparam logic [9:0] O_PROX = 10'b0100000000;
  localparam logic [9:0] O_REGE = 10'b0100100000;
  localparam logic [9:0] O_ESC  = 10'b0000010000;
  localparam logic [9:0] O_ROD  = 10'b0001000000;
  localparam logic [9:0] O_WIN  = 10'b0000001100;
  localparam logic [9:0] O_ERR  = 10'b0000001010;
  localparam logic [9:0] O_TMO  = 10'b0000001011;

  unidade_controle_exp6_desafio #(.TIMEOUT_CICLOS(8), .LARGURA_T(13)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada), .rodadaFinal(rodadaFinal),
    .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR), .registraR(registraR),
    .escreve(escreve), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );
  assign outs = {zeraE, contaE, zeraR, contaR, registraR, escreve, pronto, ganhou, perdeu, db_timeout};
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] st, input logic [9:0] o);
    total++;
    assert (db_estado === st) else begin
      bad++;
      $error("FAIL %s estado: got %h want %h", tag, db_estado, st);
    end
    total++;
    assert (outs === o) else begin
      bad++;
      $error("FAIL %s outs: got %b want %b", tag, outs, o);
    end
  endtask

  task automatic comeca();
    iniciar = 1'b1; step(); chk("start_prep", 4'h1, O_PREP);
    iniciar = 1'b0; step(); chk("start_inir", 4'h2, O_INIR);
    step(); chk("start_espera", 4'h3, O_NONE);
  endtask

  initial begin
    reset = 1'b1; step(); chk("reset", 4'h0, O_NONE);
    reset = 1'b0; step(); chk("idle", 4'h0, O_NONE);
    comeca();
    igual = 1'b1; enderecoIgualRodada = 1'b1; rodadaFinal = 1'b0;
    jogada = 1'b1; step(); chk("r0_reg", 4'h4, O_REG);
    jogada = 1'b0; step(); chk("r0_cmp", 4'h5, O_NONE);
    step(); chk("r0_espesc", 4'h7, O_NONE);
    step(); chk("r0_espesc_hold", 4'h7, O_NONE);
    jogada = 1'b1; step(); chk("r0_rege", 4'h8, O_REGE);
    jogada = 1'b0; step(); chk("r0_escreve", 4'h9, O_ESC);
    step(); chk("r0_contaR", 4'hA, O_ROD);
    step(); chk("r0_inir", 4'h2, O_INIR);
    step(); chk("r1_espera", 4'h3, O_NONE);
    enderecoIgualRodada = 1'b0;
    jogada = 1'b1; step(); chk("mid_reg", 4'h4, O_REG);
    jogada = 1'b0; step(); chk("mid_cmp", 4'h5, O_NONE);
    step(); chk("mid_prox", 4'h6, O_PROX);
    step(); chk("mid_espera", 4'h3, O_NONE);
    enderecoIgualRodada = 1'b1; rodadaFinal = 1'b1;
    jogada = 1'b1; step(); chk("win_reg", 4'h4, O_REG);
    jogada = 1'b0; step(); chk("win_cmp", 4'h5, O_NONE);
    step(); chk("win", 4'hC, O_WIN);
    step(); chk("win_hold", 4'hC, O_WIN);
    comeca();
    igual = 1'b0; rodadaFinal = 1'b0;
    jogada = 1'b1; step(); chk("err_reg", 4'h4, O_REG);
    jogada = 1'b0; step(); chk("err_cmp", 4'h5, O_NONE);
    step(); chk("err", 4'hD, O_ERR);
    step(); chk("err_hold", 4'hD, O_ERR);
    comeca();
    igual = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("tmo_before", 4'h3, O_NONE);
    step(); chk("tmo", 4'hE, O_TMO);
    step(); chk("tmo_hold", 4'hE, O_TMO);
    comeca();
    for (int i = 0; i < 7; i++) step();
    chk("race_before", 4'h3, O_NONE);
    jogada = 1'b1; step(); chk("race_jogada_wins", 4'h4, O_REG);
    jogada = 1'b0; step(); chk("race_cmp", 4'h5, O_NONE);
    step(); chk("race_espesc", 4'h7, O_NONE);
    for (int i = 0; i < 7; i++) step();
    chk("esc_before_tmo", 4'h7, O_NONE);
    step(); chk("esc_tmo", 4'hE, O_TMO);
    comeca();
    jogada = 1'b1; step(); jogada = 1'b0; step(); step();
    chk("pre_reset_espesc", 4'h7, O_NONE);
    reset = 1'b1; iniciar = 1'b1; step(); chk("reset_mid", 4'h0, O_NONE);
    step(); chk("reset_ignores_iniciar", 4'h0, O_NONE);
    reset = 1'b0; step(); chk("after_reset_start", 4'h1, O_PREP);
    iniciar = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unidade_controle_exp6_desafio.md
Name: unidade_controle_exp6_desafio

Overview:
- Moore FSM control unit for the challenge "memory game" (exp6 desafio) datapath.
- Per round, it sequences replay of the stored plays, then capture and memory write of one new play.
- Includes an internal per-play timeout timer.
- Drives the play/round counter controls, the play register load and the memory write enable, and reports pronto/ganhou/perdeu plus debug state.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed per play while waiting for a press (5 s at 1 kHz).
- LARGURA_T, 13, width of the internal timeout counter; must satisfy 2^LARGURA_T > TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; forces state inicial on the next rising edge
- iniciar  in  1  start or restart game
- jogada  in  1  one-cycle pulse from datapath edge detector when a button is pressed
- igual  in  1  registered play equals memory[endereco]
- enderecoIgualRodada  in  1  play address == round counter
- rodadaFinal  in  1  round counter == 15
- zeraE  out  1  clear play/address counter
- contaE  out  1  increment play/address counter
- zeraR  out  1  clear round counter
- contaR  out  1  increment round counter
- registraR  out  1  load button register
- escreve  out  1  memory write enable (write memory[endereco] <= registered play)
- pronto  out  1  game finished
- ganhou  out  1  all 16 rounds correct
- perdeu  out  1  wrong play or timeout
- db_timeout  out  1  game ended by timeout
- db_estado  out  4  current state code, shown on the hex display

Behaviour:
- Fixed decisions: one clock; reset synchronous, active-high. All outputs are pure decodes of the state register.
- On reset the state is inicial (0x0): every output is 0, db_estado=0, and the timer is cleared.
- States (code), listed with outputs asserted, then transitions:
  - inicial (0x0): no outputs asserted. iniciar -> preparacao.
  - preparacao (0x1): zeraE, zeraR; timer cleared. -> inicia_rodada.
  - inicia_rodada (0x2): zeraE; timer cleared. -> espera_jogada.
  - espera_jogada (0x3): timer counts. jogada -> registra; else timer==TIMEOUT_CICLOS-1 -> fim_timeout. jogada wins if both occur in the same cycle.
  - registra (0x4): registraR; timer cleared. -> comparacao.
  - comparacao (0x5): evaluated in priority order:
    - !igual -> fim_errou.
    - igual & enderecoIgualRodada & rodadaFinal -> fim_acertou.
    - igual & enderecoIgualRodada -> espera_escrita.
    - otherwise -> proxima_jogada.
  - proxima_jogada (0x6): contaE. -> espera_jogada.
  - espera_escrita (0x7): timer counts. jogada -> registra_escrita; timeout as in espera_jogada.
  - registra_escrita (0x8): registraR, contaE (address becomes rodada+1); timer cleared. -> escreve_memoria.
  - escreve_memoria (0x9): escreve. -> proxima_rodada.
  - proxima_rodada (0xA): contaR. -> inicia_rodada.
  - fim_acertou (0xC): pronto, ganhou.
  - fim_errou (0xD): pronto, perdeu.
  - fim_timeout (0xE): pronto, perdeu, db_timeout.
  - In all three fim_* states: iniciar -> preparacao; otherwise hold.
- Latency:
  - jogada pulse in espera_jogada -> registra on the next edge -> comparacao one cycle later.
  - The new play is written 3 cycles after its jogada pulse.
- Timer:
  - Counts only in the espera_* states; saturates at TIMEOUT_CICLOS-1.
  - Cleared in every non-espera state, so each play gets a full window.
- Each control output is high for exactly one cycle per visit to its state; escreve never coincides with contaE.
- Unused codes 0xB and 0xF -> inicial on the next edge.
- reset mid-game: inicial on the next edge and outputs 0 regardless of state. iniciar in the same cycle as reset is ignored.
- iniciar held high across the end of a game restarts immediately from a fim_* state.

Decomposition:
- Package jogo_pkg:
  - 4-bit state code localparams (the values above).
  - N_RODADAS=16.
  - TIMEOUT_CICLOS default.
- Sub-module contador_timeout (LARGURA_T, TIMEOUT_CICLOS):
  - Inputs: clock, reset, zera, conta.
  - Output: fim, a one-cycle-valid compare pulse.
- FSM: next-state logic and output decode in the top module.

Test Plan:
- Reset: reset=1 for 1 cycle -> db_estado=0x0 and all outputs 0; iniciar=1 -> db_estado 0x1 then 0x2, with zeraE=zeraR=1 in 0x1.
- Round 0 correct: jogada pulse with igual=1, enderecoIgualRodada=1, rodadaFinal=0 -> states 3,4,5,7. Second jogada -> states 8,9,A,2 with escreve=1 in exactly one cycle and contaR=1 in exactly one cycle.
- Mid-round replay: enderecoIgualRodada=0, igual=1 -> 5 -> 6 (contaE=1) -> 3.
- Wrong play: igual=0 in comparacao -> 0xD with pronto=1, perdeu=1, ganhou=0. Held until iniciar=1 -> 0x1.
- Win: rodadaFinal=1, enderecoIgualRodada=1, igual=1 -> 0xC with pronto=1, ganhou=1.
- Timeout (TIMEOUT_CICLOS=8): no jogada in 0x3 for 8 cycles -> 0xE with db_timeout=1, perdeu=1. jogada on cycle 8, coincident with the timeout compare -> 0x4, not 0xE. reset asserted in 0x7 -> 0x0 on the next edge.
